// File: rtl/simple_div_seq.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Results are registered on entry to DONE and held until the next one.
module simple_div_seq #(
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [K-1:0] q,
    output logic [K-1:0] r,
    output logic         div_by_zero
);

    localparam int CW = $clog2(K);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state;
    logic [K-1:0]  dvd;
    logic [K-1:0]  dvs;
    logic [K-1:0]  rem;
    logic [CW-1:0] cnt;
    logic          bz;

    logic [K:0]    shifted;
    logic          ge;
    logic [K-1:0]  rem_nx;
    logic [K-1:0]  dvd_nx;
    logic          last;

    // The dividend register doubles as the quotient shift register.
    always_comb begin
        shifted = {rem, dvd[K-1]};
        ge      = shifted >= {1'b0, dvs};
        rem_nx  = ge ? K'(shifted - {1'b0, dvs}) : shifted[K-1:0];
        dvd_nx  = {dvd[K-2:0], ge};
        last    = cnt == CW'(K - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
            bz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd   <= a;
                        dvs   <= b;
                        bz    <= (b == '0);
                        rem   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    dvd <= dvd_nx;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        q           <= dvd_nx;
                        r           <= rem_nx;
                        div_by_zero <= bz;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
